// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store unit between the EX stage and a single-beat memory bus.
//
// Accepts one load or store per transaction. The transaction runs IDLE -> WAIT -> DONE.
// A misaligned request returns an addr_error pulse instead. A missing bus_ack returns a
// bus_error pulse instead.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i            EX stage presents a memory op this cycle
//   mem_op_i               0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 8 SB, 9 SH, A SW, others no-op
//   addr_i                 byte address
//   store_data_i           store source; byte/half taken from the low bits
//   write_reg_addr_i       load destination register
//   bus_req_o, bus_we_o    bus request and write qualifier
//   bus_addr_o             word-aligned bus address
//   bus_sel_o              byte-lane enables, lane0 = bits 7:0
//   bus_wdata_o            store data replicated across lanes
//   bus_rdata_i, bus_ack_i read data and transfer complete (only looked at in WAIT)
//   stall_req_o            freeze pipeline upstream of MEM
//   result_valid_o         one-cycle completion pulse
//   load_result_o          extended load data (0 for stores)
//   write_reg_en_o/addr_o  register write-back enable and address
//   addr_error_o           one-cycle pulse on a misaligned request
//   bus_error_o            one-cycle pulse on a bus timeout
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16  // 1..255 WAIT cycles before abort
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   input  logic [3:0]  mem_op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   input  logic [4:0]  write_reg_addr_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_sel_o,
   output logic [31:0] bus_wdata_o,
   input  logic [31:0] bus_rdata_i,
   input  logic        bus_ack_i,
   output logic        stall_req_o,
   output logic        result_valid_o,
   output logic [31:0] load_result_o,
   output logic        write_reg_en_o,
   output logic [4:0]  write_reg_addr_o,
   output logic        addr_error_o,
   output logic        bus_error_o
);

   localparam logic [1:0] SzByte = 2'd0;
   localparam logic [1:0] SzHalf = 2'd1;
   localparam logic [1:0] SzWord = 2'd2;

   // Last WAIT cycle index in which an ack can still arrive.
   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   state_e      state_q;
   logic        bus_req_q, bus_we_q;
   logic [31:0] bus_addr_q, bus_wdata_q;
   logic [3:0]  bus_sel_q;
   logic        result_valid_q, write_reg_en_q;
   logic [31:0] load_result_q;
   logic [4:0]  write_reg_addr_q;
   logic        addr_error_q, bus_error_q;
   logic [7:0]  wait_cnt_q;
   logic        op_load_q, op_signed_q;
   logic [1:0]  op_size_q;
   logic [1:0]  addr_lo_q;
   logic [4:0]  dest_q;

   // Request decode
   logic        op_valid, op_load, op_signed, aligned;
   logic [1:0]  op_size;
   logic        req_ok, accept, misalign;
   logic [3:0]  sel_new;
   logic [31:0] wdata_new;

   always_comb begin
      op_valid  = 1'b1;
      op_load   = 1'b1;
      op_signed = 1'b0;
      op_size   = SzByte;
      case (mem_op_i)
         4'h0: op_signed = 1'b1;
         4'h1: ;
         4'h2: begin op_signed = 1'b1; op_size = SzHalf; end
         4'h3: op_size = SzHalf;
         4'h4: op_size = SzWord;
         4'h8: op_load = 1'b0;
         4'h9: begin op_load = 1'b0; op_size = SzHalf; end
         4'hA: begin op_load = 1'b0; op_size = SzWord; end
         default: op_valid = 1'b0;
      endcase
   end

   always_comb begin
      aligned   = 1'b1;
      sel_new   = 4'b0001 << addr_i[1:0];
      wdata_new = {4{store_data_i[7:0]}};
      case (op_size)
         SzHalf: begin
            aligned   = ~addr_i[0];
            sel_new   = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{store_data_i[15:0]}};
         end
         SzWord: begin
            aligned   = (addr_i[1:0] == 2'b00);
            sel_new   = 4'b1111;
            wdata_new = store_data_i;
         end
         default: ;
      endcase
   end

   // Gated with rst_ni so stall_req stays low while reset is held.
   assign req_ok   = rst_ni && req_valid_i && op_valid && (state_q == StIdle);
   assign accept   = req_ok && aligned;
   assign misalign = req_ok && !aligned;

   assign stall_req_o = accept || (state_q == StWait);

   // Load extraction from the latched lane offset
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] rd_ext;

   always_comb begin
      case (addr_lo_q)
         2'd0:    rd_byte = bus_rdata_i[7:0];
         2'd1:    rd_byte = bus_rdata_i[15:8];
         2'd2:    rd_byte = bus_rdata_i[23:16];
         default: rd_byte = bus_rdata_i[31:24];
      endcase
      rd_half = addr_lo_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      case (op_size_q)
         SzByte:  rd_ext = op_signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'd0, rd_byte};
         SzHalf:  rd_ext = op_signed_q ? {{16{rd_half[15]}}, rd_half} : {16'd0, rd_half};
         default: rd_ext = bus_rdata_i;
      endcase
   end

   // FSM with registered outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= StIdle;
         bus_req_q        <= 1'b0;
         bus_we_q         <= 1'b0;
         bus_addr_q       <= 32'd0;
         bus_sel_q        <= 4'd0;
         bus_wdata_q      <= 32'd0;
         result_valid_q   <= 1'b0;
         load_result_q    <= 32'd0;
         write_reg_en_q   <= 1'b0;
         write_reg_addr_q <= 5'd0;
         addr_error_q     <= 1'b0;
         bus_error_q      <= 1'b0;
         wait_cnt_q       <= 8'd0;
         op_load_q        <= 1'b0;
         op_signed_q      <= 1'b0;
         op_size_q        <= SzByte;
         addr_lo_q        <= 2'd0;
         dest_q           <= 5'd0;
      end else begin
         addr_error_q <= 1'b0;
         bus_error_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q     <= StWait;
                  bus_req_q   <= 1'b1;
                  bus_we_q    <= ~op_load;
                  bus_addr_q  <= {addr_i[31:2], 2'b00};
                  bus_sel_q   <= sel_new;
                  bus_wdata_q <= wdata_new;
                  wait_cnt_q  <= 8'd0;
                  op_load_q   <= op_load;
                  op_signed_q <= op_signed;
                  op_size_q   <= op_size;
                  addr_lo_q   <= addr_i[1:0];
                  dest_q      <= write_reg_addr_i;
               end else if (misalign) begin
                  addr_error_q <= 1'b1;
               end
            end
            StWait: begin
               // Ack takes priority over a timeout in the same cycle.
               if (bus_ack_i) begin
                  state_q        <= StDone;
                  bus_req_q      <= 1'b0;
                  bus_we_q       <= 1'b0;
                  result_valid_q <= 1'b1;
                  if (op_load_q) begin
                     write_reg_en_q   <= 1'b1;
                     write_reg_addr_q <= dest_q;
                     load_result_q    <= rd_ext;
                  end
               end else if (wait_cnt_q == TimeoutLast) begin
                  state_q     <= StIdle;
                  bus_req_q   <= 1'b0;
                  bus_we_q    <= 1'b0;
                  bus_error_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            StDone: begin
               state_q          <= StIdle;
               result_valid_q   <= 1'b0;
               write_reg_en_q   <= 1'b0;
               write_reg_addr_q <= 5'd0;
               load_result_q    <= 32'd0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_req_o        = bus_req_q;
   assign bus_we_o         = bus_we_q;
   assign bus_addr_o       = bus_addr_q;
   assign bus_sel_o        = bus_sel_q;
   assign bus_wdata_o      = bus_wdata_q;
   assign result_valid_o   = result_valid_q;
   assign load_result_o    = load_result_q;
   assign write_reg_en_o   = write_reg_en_q;
   assign write_reg_addr_o = write_reg_addr_q;
   assign addr_error_o     = addr_error_q;
   assign bus_error_o      = bus_error_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles WAIT holds bus_req without bus_ack before abort (range 1..255).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 req_valid  in  1  EX stage presents a memory op this cycle.
REQ-005 mem_op  in  4  op code: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 8 SB, 9 SH, A SW; all other codes are no-op.
REQ-006 addr  in  32  byte address of access.
REQ-007 store_data  in  32  store source; byte/half taken from low bits.
REQ-008 write_reg_addr_in  in  5  load destination register.
REQ-009 bus_req / bus_we  out  1/1  bus request; write qualifier.
REQ-010 bus_addr  out  32  word address {addr[31:2],2'b00}.
REQ-011 bus_sel  out  4  byte-lane enables, little-endian (lane0 = bits 7:0).
REQ-012 bus_wdata  out  32  store data, replicated across lanes.
REQ-013 bus_rdata / bus_ack  in  32/1  read data; transfer complete, sampled only in WAIT.
REQ-014 stall_req  out  1  freeze pipeline upstream of MEM.
REQ-015 result_valid  out  1  one-cycle completion pulse.
REQ-016 load_result  out  32  extended load data; 0 for stores.
REQ-017 write_reg_en_out / write_reg_addr_out  out  1/5  register write-back enable and address.
REQ-018 addr_error / bus_error  out  1/1  one-cycle pulses: misalignment; timeout.

Function
REQ-019 FSM states IDLE, WAIT, DONE; encoding implementation-defined.
REQ-020 IDLE: req_valid with valid mem_op and aligned addr latches op, addr, data, dest; next state WAIT.
REQ-021 Alignment: LH/LHU/SH require addr[0]=0; LW/SW require addr[1:0]=0; byte ops always aligned.
REQ-022 Misaligned request in IDLE: no bus access; addr_error=1 next cycle; result_valid=0; state stays IDLE.
REQ-023 No-op code or req_valid=0 in IDLE: no state change, no outputs asserted.
REQ-024 WAIT: bus_req=1 with bus_addr, bus_sel, bus_we, bus_wdata from latched values, held stable until exit.
REQ-025 bus_sel: byte = 1<<addr[1:0]; half = 4'b0011 (addr[1]=0) or 4'b1100; word = 4'b1111.
REQ-026 bus_wdata: SB {4{b}}, SH {2{h}}, SW word.
REQ-027 bus_ack sampled high in WAIT: capture extracted data; next state DONE; bus_req=0 in DONE.
REQ-028 Load extraction: select lane(s) by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-029 DONE (one cycle): result_valid=1; loads drive write_reg_en_out=1, write_reg_addr_out=dest, load_result=data; stores drive 0 on all three; next state IDLE.
REQ-030 Outputs of REQ-029 are 0 in all states except DONE.
REQ-031 WAIT cycle counter starts at 0 on entry; if it reaches TIMEOUT with no ack, drop bus_req, pulse bus_error next cycle, return IDLE, no result_valid.
REQ-032 bus_ack and timeout in same cycle: ack wins.
REQ-033 stall_req = (IDLE and accepted request per REQ-020) or WAIT; combinational; 0 in DONE.
REQ-034 Latency: accept at cycle N, bus_req from N+1, ack at cycle M, result_valid at M+1; minimum 3 cycles accept-to-result.
REQ-035 bus_ack outside WAIT ignored.

Reset
REQ-036 rst low forces IDLE asynchronously, mid-transfer included; bus_req, bus_we, stall_req, result_valid, write_reg_en_out, addr_error, bus_error = 0; bus_addr, bus_sel, bus_wdata, load_result, write_reg_addr_out, counter = 0.
REQ-037 First request accepted on first rising edge with rst high.

Verification
REQ-038 LB addr=0x1003, bus_rdata=0x80FF_FF12, ack after 2 WAIT cycles -> bus_sel=4'b1000, load_result=0xFFFF_FF80, write_reg_en_out=1, stall_req high 3 cycles.
REQ-039 SH addr=0x2002, store_data=0x0000_BEEF -> bus_we=1, bus_sel=4'b1100, bus_wdata=0xBEEF_BEEF; result_valid=1, write_reg_en_out=0.
REQ-040 LW addr=0x0006 -> addr_error pulse, bus_req never asserted, stall_req=0.
REQ-041 LHU addr=0x0002, no ack, TIMEOUT=4 -> bus_req high 4 cycles, bus_error pulse, IDLE, next LW accepted.
REQ-042 rst low during WAIT -> bus_req=0, stall_req=0 immediately, before next clock edge.
REQ-043 Back-to-back SW then LW with ack in first WAIT cycle -> each result_valid exactly once, correct order.
